// File: rtl/downscale_pkg.sv
`default_nettype none
// ============================================================================
// Module  : downscale_pkg
// Purpose : Shared types and constants for the bilinear downscaler and its
//           hardware step sequencer.
// Revision: 1.0 - initial release
// ============================================================================
package downscale_pkg;

    localparam int unsigned c_CNT_W_DEFAULT       = 16;
    localparam int unsigned c_TMO_W_DEFAULT       = 16;
    localparam int unsigned c_TIMEOUT_CYC_DEFAULT = 1024;

    // Q8.8 scale factors as consumed by the scaler core.
    localparam int unsigned c_SCALE_FRAC_BITS = 8;
    localparam logic [15:0] c_SCALE_ONE       = 16'h0100;
    localparam logic [15:0] c_SCALE_HALF      = 16'h0080;
    localparam logic [15:0] c_SCALE_MAX       = 16'hFFFF;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        REL  = 2'd2,
        ERR  = 2'd3
    } step_seq_state_t;

    function automatic logic seq_is_busy(input step_seq_state_t s);
        return (s == REQ) || (s == REL);
    endfunction

endpackage
`default_nettype wire

// File: rtl/hs_timeout_timer.sv
`default_nettype none
// ============================================================================
// Module  : hs_timeout_timer
// Purpose : Per-phase stall timer; expires when the count reaches limit-1,
//           a limit of zero disables it entirely.
// Revision: 1.0 - initial release
// ============================================================================
module hs_timeout_timer #(
    parameter int unsigned TMO_W = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clear_i,
    input  logic             enable_i,
    input  logic [TMO_W-1:0] limit_i,
    output logic             expired_o
);

    logic [TMO_W-1:0] count_q;
    logic [TMO_W-1:0] count_d;
    logic             w_armed;
    logic [TMO_W-1:0] w_last;

    assign w_armed = (limit_i != '0);
    assign w_last  = limit_i - TMO_W'(1);

    // Holds at the last value so the expiry stays visible until cleared.
    always_comb begin
        count_d = count_q;
        if (clear_i) begin
            count_d = '0;
        end else if (enable_i && w_armed && (count_q != w_last)) begin
            count_d = count_q + TMO_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign expired_o = enable_i && w_armed && (count_q == w_last);

endmodule
`default_nettype wire

// File: rtl/downscale_step_sequencer.sv
`default_nettype none
// ============================================================================
// Module  : downscale_step_sequencer
// Purpose : Drives the scaler core's four-phase STEP/STEP_ACK handshake for
//           N steps or until core_done, counting steps and flagging stalls.
// Revision: 1.0 - initial release
// ============================================================================
module downscale_step_sequencer
    import downscale_pkg::*;
#(
    parameter int unsigned CNT_W       = c_CNT_W_DEFAULT,
    parameter int unsigned TMO_W       = c_TMO_W_DEFAULT,
    parameter int unsigned TIMEOUT_CYC = c_TIMEOUT_CYC_DEFAULT
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             cfg_step_mode,
    input  logic             cmd_valid,
    output logic             cmd_ready,
    input  logic [CNT_W-1:0] cmd_count,
    input  logic             cmd_abort,
    input  logic             clear_err,
    output logic             step_mode,
    output logic             step,
    input  logic             step_ack,
    input  logic             core_done,
    output logic             seq_busy,
    output logic             seq_done,
    output logic [CNT_W-1:0] steps_issued,
    output logic             timeout_err
);

    localparam logic [TMO_W-1:0] c_TMO_LIMIT = TMO_W'(TIMEOUT_CYC);
    localparam logic [CNT_W-1:0] c_CNT_MAX   = '1;

    step_seq_state_t  state_q;
    step_seq_state_t  state_d;
    logic             step_q;
    logic             step_d;
    logic             step_mode_q;
    logic             seq_done_q;
    logic             seq_done_d;
    logic [CNT_W-1:0] steps_issued_q;
    logic [CNT_W-1:0] steps_issued_d;
    logic             timeout_err_q;
    logic             timeout_err_d;
    logic [CNT_W-1:0] remaining_q;
    logic [CNT_W-1:0] remaining_d;
    logic             until_done_q;
    logic             until_done_d;
    logic             abort_q;
    logic             abort_d;

    logic             w_accept;
    logic             w_busy;
    logic             w_tmo_expired;
    logic             w_tmo_clear;
    logic             w_cmd_end;

    assign w_busy    = seq_is_busy(state_q);
    assign cmd_ready = (state_q == IDLE) && step_mode_q && !timeout_err_q;
    assign w_accept  = cmd_valid && cmd_ready;

    // The phase timer restarts on every state change.
    assign w_tmo_clear = (state_d != state_q);

    hs_timeout_timer #(
        .TMO_W (TMO_W)
    ) u_timer (
        .clk       (clk),
        .rst       (rst),
        .clear_i   (w_tmo_clear),
        .enable_i  (w_busy),
        .limit_i   (c_TMO_LIMIT),
        .expired_o (w_tmo_expired)
    );

    always_comb begin
        state_d        = state_q;
        step_d         = step_q;
        seq_done_d     = 1'b0;
        steps_issued_d = steps_issued_q;
        timeout_err_d  = timeout_err_q;
        remaining_d    = remaining_q;
        until_done_d   = until_done_q;
        abort_d        = abort_q | (cmd_abort && (state_q != IDLE));
        w_cmd_end      = 1'b0;

        case (state_q)
            IDLE: begin
                if (w_accept) begin
                    remaining_d    = cmd_count;
                    until_done_d   = (cmd_count == '0);
                    steps_issued_d = '0;
                    abort_d        = 1'b0;
                    if (core_done) begin
                        seq_done_d = 1'b1;
                    end else begin
                        state_d = REQ;
                        step_d  = 1'b1;
                    end
                end
            end

            REQ: begin
                if (step_ack) begin
                    step_d  = 1'b0;
                    state_d = REL;
                end else if (w_tmo_expired) begin
                    step_d        = 1'b0;
                    timeout_err_d = 1'b1;
                    seq_done_d    = 1'b1;
                    state_d       = ERR;
                end
            end

            REL: begin
                if (!step_ack) begin
                    if (steps_issued_q != c_CNT_MAX) begin
                        steps_issued_d = steps_issued_q + CNT_W'(1);
                    end
                    if (!until_done_q) begin
                        remaining_d = remaining_q - CNT_W'(1);
                    end
                    // An abort arriving in this very cycle is honoured too.
                    w_cmd_end = (!until_done_q && (remaining_q == CNT_W'(1)))
                              || core_done || abort_q || cmd_abort;
                    if (w_cmd_end) begin
                        seq_done_d = 1'b1;
                        state_d    = IDLE;
                    end else begin
                        step_d  = 1'b1;
                        state_d = REQ;
                    end
                end else if (w_tmo_expired) begin
                    timeout_err_d = 1'b1;
                    seq_done_d    = 1'b1;
                    state_d       = ERR;
                end
            end

            ERR: begin
                step_d = 1'b0;
                if (clear_err) begin
                    timeout_err_d = 1'b0;
                    state_d       = IDLE;
                end
            end

            default: begin
                step_d  = 1'b0;
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q        <= IDLE;
            step_q         <= 1'b0;
            step_mode_q    <= 1'b0;
            seq_done_q     <= 1'b0;
            steps_issued_q <= '0;
            timeout_err_q  <= 1'b0;
            remaining_q    <= '0;
            until_done_q   <= 1'b0;
            abort_q        <= 1'b0;
        end else begin
            state_q        <= state_d;
            step_q         <= step_d;
            step_mode_q    <= cfg_step_mode;
            seq_done_q     <= seq_done_d;
            steps_issued_q <= steps_issued_d;
            timeout_err_q  <= timeout_err_d;
            remaining_q    <= remaining_d;
            until_done_q   <= until_done_d;
            abort_q        <= abort_d;
        end
    end

    assign step         = step_q;
    assign step_mode    = step_mode_q;
    assign seq_busy     = w_busy;
    assign seq_done     = seq_done_q;
    assign steps_issued = steps_issued_q;
    assign timeout_err  = timeout_err_q;

endmodule
`default_nettype wire

// File: tb/tb_downscale_step_sequencer.sv
`default_nettype none
// ============================================================================
// Module  : tb_downscale_step_sequencer
// Purpose : Scoreboard bench for downscale_step_sequencer with a behavioural
//           scaler-core model and randomized step commands.
// Revision: 1.0 - initial release
// ============================================================================
module tb_downscale_step_sequencer;

    localparam int unsigned CNT_W       = 4;
    localparam int unsigned TMO_W       = 8;
    localparam int unsigned TIMEOUT_CYC = 8;
    localparam int          CNT_MAX     = (1 << CNT_W) - 1;

    logic             clk = 1'b0;
    logic             rst;
    logic             cfg_step_mode;
    logic             cmd_valid;
    logic             cmd_ready;
    logic [CNT_W-1:0] cmd_count;
    logic             cmd_abort;
    logic             clear_err;
    logic             step_mode;
    logic             step;
    logic             step_ack;
    logic             core_done;
    logic             seq_busy;
    logic             seq_done;
    logic [CNT_W-1:0] steps_issued;
    logic             timeout_err;

    always #5 clk = ~clk;

    downscale_step_sequencer #(
        .CNT_W       (CNT_W),
        .TMO_W       (TMO_W),
        .TIMEOUT_CYC (TIMEOUT_CYC)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .cfg_step_mode (cfg_step_mode),
        .cmd_valid     (cmd_valid),
        .cmd_ready     (cmd_ready),
        .cmd_count     (cmd_count),
        .cmd_abort     (cmd_abort),
        .clear_err     (clear_err),
        .step_mode     (step_mode),
        .step          (step),
        .step_ack      (step_ack),
        .core_done     (core_done),
        .seq_busy      (seq_busy),
        .seq_done      (seq_done),
        .steps_issued  (steps_issued),
        .timeout_err   (timeout_err)
    );

    typedef struct packed {
        int steps;
        int rises;
        bit err;
    } exp_t;

    exp_t sb_q[$];
    int   checks = 0;
    int   errors = 0;

    // Core-model configuration, written by the stimulus, read by the core model.
    int ack_dly = 0, rel_dly = 0, stuck_at = 0, done_at = 0, abort_at = 0;
    bit done_preset = 1'b0;
    int gen = 0;

    // Observations published by the core model and monitor.
    int hs = 0, rises = 0, hi_len = 0, rise_cyc = 0, done_cyc = 0;
    int cyc = 0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input longint act, input longint exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Expected outcome straight from the command rules: the command ends at the
    // earliest of count, core_done, abort; a never-acked step ends it in error.
    function automatic exp_t model(input int count, input int d, input int ab,
                                   input int s, input bit pre);
        exp_t e;
        int   n;
        e.err = 1'b0; e.steps = 0; e.rises = 0;
        if (pre) return e;
        n = 1 << 30;
        if (count > 0) n = count;
        if (d > 0 && d < n) n = d;
        if (ab > 0 && ab < n) n = ab;
        if (s > 0 && s <= n) begin
            e.err = 1'b1; e.rises = s; e.steps = s - 1;
        end else begin
            e.rises = n; e.steps = n;
        end
        if (e.steps > CNT_MAX) e.steps = CNT_MAX;
        return e;
    endfunction

    // Behavioural scaler core: acks each step after ack_dly cycles, releases
    // after rel_dly, raises core_done on the release of handshake done_at.
    initial begin : core_model
        int last_gen;
        int cnt;
        int hi_run;
        bit abort_sent;
        bit prev_step;
        last_gen = 0; cnt = 0; hi_run = 0; abort_sent = 1'b0; prev_step = 1'b0;
        step_ack = 1'b0; core_done = 1'b0; cmd_abort = 1'b0;
        forever begin
            @(negedge clk);
            cmd_abort = 1'b0;
            if (rst) begin
                step_ack = 1'b0; cnt = 0;
            end
            if (gen != last_gen) begin
                last_gen = gen; hs = 0; rises = 0; cnt = 0; hi_run = 0;
                abort_sent = 1'b0; step_ack = 1'b0; core_done = done_preset;
            end
            if (step && !prev_step) begin
                if (rises == 0) rise_cyc = cyc;
                rises++;
                check("ack low at step rise", step_ack, 0);
            end
            if (step) begin
                hi_run++;
            end else if (hi_run > 0) begin
                hi_len = hi_run; hi_run = 0;
            end
            if (!step_ack) begin
                if (step) begin
                    cnt++;
                    if (hs + 1 == abort_at && !abort_sent) begin
                        cmd_abort = 1'b1; abort_sent = 1'b1;
                    end
                    if (hs + 1 != stuck_at && cnt > ack_dly) begin
                        step_ack = 1'b1; cnt = 0; hs++;
                    end
                end
            end else if (!step) begin
                cnt++;
                if (cnt > rel_dly) begin
                    step_ack = 1'b0; cnt = 0;
                    if (hs == done_at) core_done = 1'b1;
                end
            end
            prev_step = step;
        end
    end

    initial begin : monitor
        exp_t e;
        forever begin
            @(negedge clk);
            if (!rst && seq_done) begin
                done_cyc = cyc;
                if (sb_q.size() == 0) begin
                    checks++; errors++;
                    $display("FAIL unexpected seq_done: steps_issued %0d with no command pending", steps_issued);
                end else begin
                    e = sb_q.pop_front();
                    check("steps_issued", steps_issued, e.steps);
                    check("timeout_err at done", timeout_err, e.err);
                    check("step low at done", step, 0);
                end
            end
        end
    end

    task automatic start_cmd(input int count, input int a, input int r, input int s,
                             input int d, input int ab, input bit pre, input bit push,
                             output exp_t e);
        bit ok;
        @(negedge clk);
        ack_dly = a; rel_dly = r; stuck_at = s; done_at = d; abort_at = ab;
        done_preset = pre; gen++;
        e = model(count, d, ab, s, pre);
        if (push) sb_q.push_back(e);
        @(negedge clk);
        cmd_valid = 1'b1;
        cmd_count = CNT_W'(count);
        ok = 1'b0;
        for (int i = 0; i < 20; i++) begin
            if (cmd_ready) begin
                ok = 1'b1;
                break;
            end
            @(negedge clk);
        end
        @(negedge clk);
        cmd_valid = 1'b0;
        check("command accepted", ok, 1);
        if (!ok && push) sb_q.delete();
    endtask

    task automatic wait_cmd();
        for (int i = 0; i < 600 && sb_q.size() != 0; i++) begin
            @(negedge clk);
            #1;
        end
        check("command completes", sb_q.size(), 0);
        sb_q.delete();
    endtask

    task automatic finish_cmd(input exp_t e);
        check("step pulses", rises, e.rises);
        check("idle after command", seq_busy, 0);
        if (e.err) begin
            repeat (2) @(negedge clk);
            check("err sticky", timeout_err, 1);
            check("cmd_ready low in err", cmd_ready, 0);
            check("step low in err", step, 0);
            clear_err = 1'b1;
            @(negedge clk);
            clear_err = 1'b0;
            check("err cleared", timeout_err, 0);
            check("cmd_ready after clear", cmd_ready, 1);
        end else begin
            check("no timeout_err", timeout_err, 0);
        end
    endtask

    task automatic run_cmd(input int count, input int a, input int r, input int s,
                           input int d, input int ab, input bit pre, output int lat);
        exp_t e;
        start_cmd(count, a, r, s, d, ab, pre, 1'b1, e);
        wait_cmd();
        lat = done_cyc - rise_cyc;
        finish_cmd(e);
    endtask

    initial begin : watchdog
        #900_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin : stimulus
        int   lat;
        int   cnt, a, r, s, d, ab;
        bit   pre;
        exp_t e;

        rst = 1'b1; cfg_step_mode = 1'b0; cmd_valid = 1'b0; cmd_count = '0;
        clear_err = 1'b0;
        repeat (3) @(negedge clk);
        check("reset step", step, 0);
        check("reset step_mode", step_mode, 0);
        check("reset seq_busy", seq_busy, 0);
        check("reset seq_done", seq_done, 0);
        check("reset steps_issued", steps_issued, 0);
        check("reset timeout_err", timeout_err, 0);
        check("reset cmd_ready", cmd_ready, 0);
        rst = 1'b0;
        repeat (2) @(negedge clk);
        check("cmd_ready without step mode", cmd_ready, 0);
        cfg_step_mode = 1'b1;
        @(negedge clk);
        check("step_mode follows cfg", step_mode, 1);
        check("cmd_ready in step mode", cmd_ready, 1);

        // Slow ack, single step.
        run_cmd(1, 2, 0, 0, 0, 0, 1'b0, lat);
        check("single step latency", lat, 4);
        check("step high cycles", hi_len, 3);

        // Immediate acks: two cycles per step.
        run_cmd(3, 0, 0, 0, 0, 0, 1'b0, lat);
        check("three step latency", lat, 6);
        check("step high cycles fast", hi_len, 1);

        // Step until core_done arrives with the 5th release.
        run_cmd(0, 1, 1, 0, 5, 0, 1'b0, lat);

        // Stuck core: timeout exactly TIMEOUT_CYC cycles after step rises.
        run_cmd(1, 0, 0, 1, 0, 0, 1'b0, lat);
        check("timeout latency", lat, TIMEOUT_CYC);
        check("step high until timeout", hi_len, TIMEOUT_CYC);

        // Abort in the 4th request completes that handshake then stops.
        run_cmd(10, 1, 0, 0, 0, 4, 1'b0, lat);

        // core_done already high at accept: zero steps.
        run_cmd(3, 0, 0, 0, 0, 0, 1'b1, lat);

        // Counter saturation.
        run_cmd(0, 0, 0, 0, 18, 0, 1'b0, lat);

        // Step mode dropped mid-command: command still finishes.
        start_cmd(3, 2, 1, 0, 0, 0, 1'b0, 1'b1, e);
        cfg_step_mode = 1'b0;
        wait_cmd();
        finish_cmd(e);
        check("step_mode follows drop", step_mode, 0);
        check("cmd_ready with mode off", cmd_ready, 0);
        cfg_step_mode = 1'b1;
        @(negedge clk);

        // Reset in the middle of a request.
        start_cmd(5, 4, 0, 0, 0, 0, 1'b0, 1'b0, e);
        check("step high before reset", step, 1);
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        check("step after reset", step, 0);
        check("busy after reset", seq_busy, 0);
        check("steps after reset", steps_issued, 0);
        check("step_mode after reset", step_mode, 0);
        check("cmd_ready after reset", cmd_ready, 0);
        rst = 1'b0;
        cfg_step_mode = 1'b0;
        cmd_valid = 1'b1;
        repeat (3) @(negedge clk);
        check("no accept with mode off", seq_busy, 0);
        check("cmd_ready held low", cmd_ready, 0);
        cmd_valid = 1'b0;
        cfg_step_mode = 1'b1;
        @(negedge clk);
        run_cmd(2, 1, 2, 0, 0, 0, 1'b0, lat);

        // Randomized commands.
        for (int k = 0; k < 40; k++) begin
            cnt = int'($urandom_range(15, 0));
            a   = int'($urandom_range(4, 0));
            r   = int'($urandom_range(4, 0));
            d   = ($urandom_range(1, 0) == 1) ? int'($urandom_range(cnt + 2, 1)) : 0;
            if (cnt == 0) d = int'($urandom_range(18, 1));
            ab  = ($urandom_range(3, 0) == 0) ? int'($urandom_range(6, 1)) : 0;
            s   = ($urandom_range(6, 0) == 0) ? int'($urandom_range(4, 1)) : 0;
            pre = ($urandom_range(9, 0) == 0);
            run_cmd(cnt, a, r, s, d, ab, pre, lat);
        end

        repeat (3) @(negedge clk);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
